lcd_glyph_render: RTL and testbench

- Parametrised successor to the fixed 12x6/16x8 character drawer.
- Renders one glyph of any font size FONT_W x FONT_H from an external font ROM onto the SPI LCD as a 9-bit command/data word stream ({dc, byte}).
- Foreground and background colours are runtime inputs; ROM latency and base address are parameters.
- Sits between the screen-content controller (start/done) and the shared SPI byte writer (en_write/wr_done).

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_glyph_addr_gen.sv | 50 +++++
 rtl/lcd_glyph_render.sv | 241 ++++++++++++++++++++++++
 tb/tb_lcd_glyph_render.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD definitions: controller command bytes, RGB565 colours, the glyph
// renderer state encoding and the dc-tagged 9-bit word builder.
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WIN   = 3'd1,
        ST_FETCH = 3'd2,
        ST_PIX   = 3'd3,
        ST_DONE  = 3'd4
    } lcd_state_t;

    // dc = 0 marks a command byte, dc = 1 a parameter/pixel byte.
    function automatic logic [8:0] lcd_word(input logic dc, input logic [7:0] data);
        return {dc, data};
    endfunction

    function automatic int bytes_per_row(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/lcd_glyph_addr_gen.sv
// Font ROM address generator: glyph index, registered ROM word address and the
// number of valid pixels held in ROM byte b of a glyph row.
module lcd_glyph_addr_gen
    import lcd_pkg::*;
#(
    parameter int FONT_W     = 8,
    parameter int FONT_H     = 16,
    parameter int FIRST_CHAR = 32,
    parameter int LAST_CHAR  = 126,
    parameter int ROM_BASE   = 0,
    parameter int ROM_AW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        ascii,
    input  logic [5:0]        row,
    input  logic [1:0]        b,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [3:0]        ppb
);

    localparam int BPR = bytes_per_row(FONT_W);

    int                code;
    int                glyph;
    int                rem;
    logic [ROM_AW-1:0] addr_next;

    always_comb begin
        code  = int'({25'd0, ascii});
        glyph = 0;
        if (code >= FIRST_CHAR && code <= LAST_CHAR) begin
            glyph = code - FIRST_CHAR;
        end
        // Arithmetic is done in 32 bits and cut to ROM_AW, so overflow wraps.
        addr_next = ROM_AW'(ROM_BASE + glyph * FONT_H * BPR
                            + int'({26'd0, row}) * BPR + int'({30'd0, b}));
        rem = FONT_W - 8 * int'({30'd0, b});
        ppb = (rem >= 8) ? 4'd8 : 4'(rem);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
        end else begin
            rom_addr <= addr_next;
        end
    end

endmodule

// File: rtl/lcd_glyph_render.sv
// Draws one FONT_W x FONT_H glyph from a font ROM as a {dc,byte} word stream for
// the shared SPI writer. Optional macro LCD_GLYPH_INVERT_EN adds the invert input.
module lcd_glyph_render
    import lcd_pkg::*;
#(
    parameter int FONT_W     = 8,
    parameter int FONT_H     = 16,
    parameter int FIRST_CHAR = 32,
    parameter int LAST_CHAR  = 126,
    parameter int ROM_BASE   = 0,
    parameter int ROM_AW     = 12,
    parameter int ROM_LAT    = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [6:0]        ascii,
    input  logic [8:0]        x0,
    input  logic [8:0]        y0,
    input  logic [15:0]       fg_color,
    input  logic [15:0]       bg_color,
`ifdef LCD_GLYPH_INVERT_EN
    input  logic              invert,
`endif
    input  logic              wr_done,
    output logic              en_write,
    output logic [8:0]        lcd_data,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_q,
    output logic              busy,
    output logic              done,
    output lcd_state_t        fsm_state
);

    // Handshake: en_write rises together with a new lcd_data and holds until a
    // cycle with wr_done high; that cycle consumes the word and drops en_write,
    // so the next word appears one cycle later at the earliest. wr_done seen
    // while en_write is low has no effect.

    localparam int         BPR      = bytes_per_row(FONT_W);
    localparam logic [1:0] B_LAST   = 2'(BPR - 1);
    localparam logic [5:0] ROW_LAST = 6'(FONT_H - 1);
    // rom_addr is registered, so the data is sampled one cycle past ROM_LAT.
    localparam logic [3:0] LOAD_AT  = 4'(ROM_LAT + 1);
    localparam logic [3:0] WIN_LAST = 4'd10;

    lcd_state_t  state;
    lcd_state_t  next_state;

    logic [6:0]  ascii_q;
    logic [8:0]  x0_q;
    logic [8:0]  y0_q;
    logic [15:0] fg_q;
    logic [15:0] bg_q;
    logic [3:0]  word_idx;
    logic [5:0]  row;
    logic [1:0]  b;
    logic [3:0]  lat_cnt;
    logic [7:0]  shreg;
    logic [3:0]  pix_cnt;
    logic        half;
    logic [3:0]  ppb;

    logic [15:0] fg_eff;
    logic [15:0] bg_eff;
    logic [15:0] pix_color;
    logic [8:0]  x1;
    logic [8:0]  y1;
    logic [8:0]  win_word;
    logic [8:0]  pix_word;
    logic        consume;
    logic        present;
    logic        fetch_done;
    logic        byte_end;
    logic        byte_more;
    logic        row_more;

`ifdef LCD_GLYPH_INVERT_EN
    logic inv_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            inv_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            inv_q <= invert;
        end
    end

    assign fg_eff = inv_q ? bg_q : fg_q;
    assign bg_eff = inv_q ? fg_q : bg_q;
`else
    assign fg_eff = fg_q;
    assign bg_eff = bg_q;
`endif

    lcd_glyph_addr_gen #(
        .FONT_W    (FONT_W),
        .FONT_H    (FONT_H),
        .FIRST_CHAR(FIRST_CHAR),
        .LAST_CHAR (LAST_CHAR),
        .ROM_BASE  (ROM_BASE),
        .ROM_AW    (ROM_AW)
    ) u_addr_gen (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .ascii   (ascii_q),
        .row     (row),
        .b       (b),
        .rom_addr(rom_addr),
        .ppb     (ppb)
    );

    always_comb begin
        x1 = x0_q + 9'(FONT_W - 1);
        y1 = y0_q + 9'(FONT_H - 1);
        case (word_idx)
            4'd0:    win_word = lcd_word(1'b0, CMD_CASET);
            4'd1:    win_word = lcd_word(1'b1, {7'd0, x0_q[8]});
            4'd2:    win_word = lcd_word(1'b1, x0_q[7:0]);
            4'd3:    win_word = lcd_word(1'b1, {7'd0, x1[8]});
            4'd4:    win_word = lcd_word(1'b1, x1[7:0]);
            4'd5:    win_word = lcd_word(1'b0, CMD_RASET);
            4'd6:    win_word = lcd_word(1'b1, {7'd0, y0_q[8]});
            4'd7:    win_word = lcd_word(1'b1, y0_q[7:0]);
            4'd8:    win_word = lcd_word(1'b1, {7'd0, y1[8]});
            4'd9:    win_word = lcd_word(1'b1, y1[7:0]);
            default: win_word = lcd_word(1'b0, CMD_RAMWR);
        endcase
        pix_color = shreg[0] ? fg_eff : bg_eff;
        pix_word  = lcd_word(1'b1, half ? pix_color[7:0] : pix_color[15:8]);
    end

    assign consume    = en_write && wr_done;
    assign present    = !en_write && (state == ST_WIN || state == ST_PIX);
    assign fetch_done = (state == ST_FETCH) && (lat_cnt == LOAD_AT);
    assign byte_end   = half && (pix_cnt == ppb - 4'd1);
    assign byte_more  = (b != B_LAST);
    assign row_more   = (row != ROW_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_WIN;
            ST_WIN:   if (consume && word_idx == WIN_LAST) next_state = ST_FETCH;
            ST_FETCH: if (fetch_done) next_state = ST_PIX;
            ST_PIX: begin
                if (consume && byte_end) begin
                    next_state = (byte_more || row_more) ? ST_FETCH : ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ascii_q  <= 7'd0;
            x0_q     <= 9'd0;
            y0_q     <= 9'd0;
            fg_q     <= RGB565_BLACK;
            bg_q     <= RGB565_BLACK;
            word_idx <= 4'd0;
            row      <= 6'd0;
            b        <= 2'd0;
            lat_cnt  <= 4'd0;
            shreg    <= 8'd0;
            pix_cnt  <= 4'd0;
            half     <= 1'b0;
            en_write <= 1'b0;
            lcd_data <= 9'd0;
        end else begin
            if (state == ST_IDLE && start) begin
                ascii_q  <= ascii;
                x0_q     <= x0;
                y0_q     <= y0;
                fg_q     <= fg_color;
                bg_q     <= bg_color;
                word_idx <= 4'd0;
                row      <= 6'd0;
                b        <= 2'd0;
                lat_cnt  <= 4'd0;
                pix_cnt  <= 4'd0;
                half     <= 1'b0;
            end

            if (present) begin
                en_write <= 1'b1;
                lcd_data <= (state == ST_WIN) ? win_word : pix_word;
            end else if (consume) begin
                en_write <= 1'b0;
            end

            if (consume && state == ST_WIN) begin
                word_idx <= word_idx + 4'd1;
            end

            // Each pixel is two words; the shift register advances after the low byte.
            if (consume && state == ST_PIX) begin
                if (!half) begin
                    half <= 1'b1;
                end else begin
                    half    <= 1'b0;
                    shreg   <= shreg >> 1;
                    pix_cnt <= pix_cnt + 4'd1;
                    if (byte_end) begin
                        pix_cnt <= 4'd0;
                        if (byte_more) begin
                            b <= b + 2'd1;
                        end else if (row_more) begin
                            row <= row + 6'd1;
                            b   <= 2'd0;
                        end
                    end
                end
            end

            if (state == ST_FETCH) begin
                if (fetch_done) begin
                    shreg   <= rom_q;
                    lat_cnt <= 4'd0;
                end else begin
                    lat_cnt <= lat_cnt + 4'd1;
                end
            end
        end
    end

    assign busy      = (state == ST_WIN) || (state == ST_FETCH) || (state == ST_PIX);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_lcd_glyph_render.sv
// Bench for lcd_glyph_render: an 8x16 and a 12x12 instance, a latency-accurate ROM
// model, an acking writer model and a pixel-level reference model of the word stream.
module tb_lcd_glyph_render;
    import lcd_pkg::*;

    localparam int AW = 12;
`ifdef LCD_GLYPH_INVERT_EN
    localparam bit INV_BUILD = 1'b1;
`else
    localparam bit INV_BUILD = 1'b0;
`endif

    logic clk;
    logic rst;

    logic          start_s    [2];
    logic [6:0]    ascii_s    [2];
    logic [8:0]    x0_s       [2];
    logic [8:0]    y0_s       [2];
    logic [15:0]   fg_s       [2];
    logic [15:0]   bg_s       [2];
    logic          inv_s      [2];
    logic          wr_done_s  [2];
    logic          en_write_s [2];
    logic [8:0]    lcd_data_s [2];
    logic [AW-1:0] rom_addr_s [2];
    logic [7:0]    rom_q_s    [2];
    logic          busy_s     [2];
    logic          done_s     [2];
    lcd_state_t    fsm_s      [2];

    int fw   [2] = '{8, 12};
    int fh   [2] = '{16, 12};
    int base [2] = '{0, 100};

    logic [7:0] rom_mem [2][4096];
    logic [7:0] pipe_a [2];
    logic [7:0] pipe_b [3];

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    int checks;
    int errors;
    int done_cnt [2];
    int ack_del  [2];
    bit stray_en [2];

    lcd_glyph_render #(
        .FONT_W(8), .FONT_H(16), .ROM_BASE(0), .ROM_AW(AW), .ROM_LAT(2)
    ) dut_a (
        .sys_clk(clk), .sys_rst(rst), .start(start_s[0]), .ascii(ascii_s[0]),
        .x0(x0_s[0]), .y0(y0_s[0]), .fg_color(fg_s[0]), .bg_color(bg_s[0]),
`ifdef LCD_GLYPH_INVERT_EN
        .invert(inv_s[0]),
`endif
        .wr_done(wr_done_s[0]), .en_write(en_write_s[0]), .lcd_data(lcd_data_s[0]),
        .rom_addr(rom_addr_s[0]), .rom_q(rom_q_s[0]), .busy(busy_s[0]),
        .done(done_s[0]), .fsm_state(fsm_s[0])
    );

    lcd_glyph_render #(
        .FONT_W(12), .FONT_H(12), .ROM_BASE(100), .ROM_AW(AW), .ROM_LAT(3)
    ) dut_b (
        .sys_clk(clk), .sys_rst(rst), .start(start_s[1]), .ascii(ascii_s[1]),
        .x0(x0_s[1]), .y0(y0_s[1]), .fg_color(fg_s[1]), .bg_color(bg_s[1]),
`ifdef LCD_GLYPH_INVERT_EN
        .invert(inv_s[1]),
`endif
        .wr_done(wr_done_s[1]), .en_write(en_write_s[1]), .lcd_data(lcd_data_s[1]),
        .rom_addr(rom_addr_s[1]), .rom_q(rom_q_s[1]), .busy(busy_s[1]),
        .done(done_s[1]), .fsm_state(fsm_s[1])
    );

    // Clock and ROM models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe_a[0] <= rom_mem[0][rom_addr_s[0]];
        pipe_a[1] <= pipe_a[0];
        pipe_b[0] <= rom_mem[1][rom_addr_s[1]];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign rom_q_s[0] = pipe_a[1];
    assign rom_q_s[1] = pipe_b[2];

    always @(negedge clk) begin
        if (done_s[0] === 1'b1) done_cnt[0]++;
        if (done_s[1] === 1'b1) done_cnt[1]++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_word(input logic [8:0] w);
        logic [8:0] e;
        got_q.push_back(w);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word actual=%0h expected=none", w);
        end else begin
            e = exp_q.pop_front();
            if (w !== e) begin
                errors++;
                $display("FAIL word_%0d actual=%0h expected=%0h", got_q.size() - 1, w, e);
            end
        end
    endtask

    // Writer model: acks each word after ack_del cycles (0 = random 1..4).
    task automatic writer(input int s);
        int cnt;
        int del;
        cnt = 0;
        del = 1;
        forever begin
            @(negedge clk);
            wr_done_s[s] = 1'b0;
            if (en_write_s[s] !== 1'b1) begin
                cnt = 0;
                if (stray_en[s] && $urandom_range(0, 4) == 0) wr_done_s[s] = 1'b1;
            end else begin
                if (cnt == 0) del = (ack_del[s] == 0) ? $urandom_range(1, 4) : ack_del[s];
                cnt++;
                if (cnt >= del) begin
                    wr_done_s[s] = 1'b1;
                    cnt = 0;
                    check_word(lcd_data_s[s]);
                end
            end
        end
    endtask

    initial writer(0);
    initial writer(1);

    // Reference model: whole-glyph word list from the pixel grid.
    task automatic build_expected(input int s, input logic [6:0] a, input logic [8:0] x0,
                                  input logic [8:0] y0, input logic [15:0] fg,
                                  input logic [15:0] bg, input logic inv);
        int g, w, h, bpr, addr;
        logic [8:0]  x1, y1;
        logic [7:0]  rb;
        logic [15:0] col, fg_e, bg_e;
        w   = fw[s];
        h   = fh[s];
        bpr = (w + 7) / 8;
        g   = (int'(a) >= 32 && int'(a) <= 126) ? int'(a) - 32 : 0;
        x1  = x0 + 9'(w - 1);
        y1  = y0 + 9'(h - 1);
        fg_e = (INV_BUILD && inv) ? bg : fg;
        bg_e = (INV_BUILD && inv) ? fg : bg;
        exp_q.delete();
        exp_q.push_back(9'h02A);
        exp_q.push_back({8'h80, x0[8]});
        exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({8'h80, x1[8]});
        exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back(9'h02B);
        exp_q.push_back({8'h80, y0[8]});
        exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({8'h80, y1[8]});
        exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back(9'h02C);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                addr = (base[s] + g * h * bpr + r * bpr + c / 8) % 4096;
                rb   = rom_mem[s][addr];
                col  = rb[c % 8] ? fg_e : bg_e;
                exp_q.push_back({1'b1, col[15:8]});
                exp_q.push_back({1'b1, col[7:0]});
            end
        end
    endtask

    task automatic start_glyph(input int s, input logic [6:0] a, input logic [8:0] x0,
                               input logic [8:0] y0, input logic [15:0] fg,
                               input logic [15:0] bg, input logic inv, input int ack);
        build_expected(s, a, x0, y0, fg, bg, inv);
        got_q.delete();
        ack_del[s] = ack;
        @(negedge clk);
        ascii_s[s] = a;
        x0_s[s]    = x0;
        y0_s[s]    = y0;
        fg_s[s]    = fg;
        bg_s[s]    = bg;
        inv_s[s]   = inv;
        start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        chk("busy_rise", busy_s[s], 1);
    endtask

    task automatic run_glyph(input int s, input logic [6:0] a, input logic [8:0] x0,
                             input logic [8:0] y0, input logic [15:0] fg,
                             input logic [15:0] bg, input logic inv, input int ack,
                             input int total, input bit disturb);
        int d0;
        bit seen;
        d0 = done_cnt[s];
        stray_en[s] = disturb;
        start_glyph(s, a, x0, y0, fg, bg, inv, ack);
        seen = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (done_s[s] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (disturb && i == 100) begin
                start_s[s] = 1'b1;
                ascii_s[s] = 7'($urandom_range(0, 127));
                x0_s[s]    = 9'($urandom);
                fg_s[s]    = 16'($urandom);
                inv_s[s]   = ~inv;
            end
            if (disturb && i == 101) start_s[s] = 1'b0;
            @(negedge clk);
        end
        chk("done_seen", seen, 1);
        chk("busy_in_done", busy_s[s], 0);
        if (disturb) start_s[s] = 1'b1;
        @(negedge clk);
        start_s[s] = 1'b0;
        chk("done_one_cycle", done_s[s], 0);
        @(negedge clk);
        #1;
        chk("start_in_done_ignored", busy_s[s], 0);
        chk("done_count", done_cnt[s] - d0, 1);
        chk("word_total", got_q.size(), total);
        chk("exp_left", exp_q.size(), 0);
        stray_en[s] = 1'b0;
    endtask

    typedef struct {
        int         s;
        logic [6:0] a;
        logic [8:0] x0;
        logic [8:0] y0;
        logic [15:0] fg;
        logic [15:0] bg;
        logic       inv;
        int         ack;
        int         total;
        logic [8:0] w3;
        logic [8:0] w4;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d0;
        bit reached;
        int s;
        vecs[0] = '{0, 7'h41, 9'd10,  9'd20,  16'hF800, 16'h0000, 1'b0, 3, 267, 9'h100, 9'h111};
        vecs[1] = '{0, 7'h20, 9'd508, 9'd0,   16'hFFFF, 16'h001F, 1'b0, 3, 267, 9'h100, 9'h103};
        vecs[2] = '{0, 7'h10, 9'd0,   9'd0,   16'hFFFF, 16'h001F, 1'b0, 2, 267, 9'h100, 9'h107};
        vecs[3] = '{1, 7'h21, 9'd100, 9'd50,  16'h07E0, 16'h1234, 1'b0, 3, 299, 9'h100, 9'h16F};
        vecs[4] = '{1, 7'h7E, 9'd511, 9'd300, 16'hABCD, 16'h5555, 1'b0, 0, 299, 9'h100, 9'h10A};
        vecs[5] = '{0, 7'h7F, 9'd256, 9'd496, 16'hC0DE, 16'hBEEF, 1'b0, 0, 267, 9'h101, 9'h107};
        vecs[6] = '{0, 7'h41, 9'd10,  9'd20,  16'hF800, 16'h0000, 1'b1, 1, 267, 9'h100, 9'h111};

        checks = 0;
        errors = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]  = 1'b0;
            ascii_s[i]  = 7'd0;
            x0_s[i]     = 9'd0;
            y0_s[i]     = 9'd0;
            fg_s[i]     = 16'd0;
            bg_s[i]     = 16'd0;
            inv_s[i]    = 1'b0;
            done_cnt[i] = 0;
            ack_del[i]  = 3;
            stray_en[i] = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4096; j++)
                rom_mem[i][j] = 8'($urandom);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_en_write", en_write_s[i], 0);
            chk("rst_lcd_data", lcd_data_s[i], 0);
            chk("rst_rom_addr", rom_addr_s[i], 0);
            chk("rst_busy", busy_s[i], 0);
            chk("rst_done", done_s[i], 0);
            chk("rst_state", fsm_s[i], ST_IDLE);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_glyph(vecs[v].s, vecs[v].a, vecs[v].x0, vecs[v].y0, vecs[v].fg, vecs[v].bg,
                      vecs[v].inv, vecs[v].ack, vecs[v].total, 1'b0);
            if (got_q.size() > 4) begin
                chk("x1_hi_word", got_q[3], vecs[v].w3);
                chk("x1_lo_word", got_q[4], vecs[v].w4);
            end else begin
                chk("window_words_present", got_q.size(), 11);
            end
        end

        // Stray wr_done, a second start mid-glyph and a start in the DONE cycle.
        run_glyph(0, 7'h4D, 9'd40, 9'd60, 16'h1F00, 16'h00E0, 1'b0, 0, 267, 1'b1);
        run_glyph(1, 7'h30, 9'd7, 9'd9, 16'h8001, 16'h7FFE, 1'b1, 0, 299, 1'b1);

        // Reset in the middle of the pixel phase, then a fresh glyph.
        d0 = done_cnt[0];
        start_glyph(0, 7'h52, 9'd1, 9'd2, 16'hFFFF, 16'h0000, 1'b0, 1);
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (got_q.size() >= 60) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("pix_reached", reached, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midrst_en_write", en_write_s[0], 0);
        chk("midrst_lcd_data", lcd_data_s[0], 0);
        chk("midrst_rom_addr", rom_addr_s[0], 0);
        chk("midrst_busy", busy_s[0], 0);
        chk("midrst_done", done_s[0], 0);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_q.delete();
        repeat (30) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt[0] - d0, 0);
        chk("abort_idle", busy_s[0], 0);
        chk("abort_no_write", en_write_s[0], 0);
        run_glyph(0, 7'h52, 9'd1, 9'd2, 16'hFFFF, 16'h0000, 1'b0, 0, 267, 1'b0);

        // Randomised glyphs against the reference model.
        for (int k = 0; k < 6; k++) begin
            s = $urandom_range(0, 1);
            run_glyph(s, 7'($urandom_range(0, 127)), 9'($urandom), 9'($urandom),
                      16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 0,
                      11 + 2 * fw[s] * fh[s], 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
